// File: rtl/multicycle_controller_if.sv
// Control bus between multicycle_controller and the RV32I datapath: instruction
// fields and ALU flags towards the controller, enables and mux selects back.
interface multicycle_controller_if;
   logic [6:0] opcode;
   logic [2:0] func3;
   logic [6:0] func7;
   logic       zero;
   logic       sign;
   logic       PCWrite;
   logic       AdrSrc;
   logic       MemWrite;
   logic       IRWrite;
   logic       RegWrite;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ResultSrc;
   logic [2:0] ALUControl;
   logic [2:0] ImmSrc;
   logic       instr_done;
   logic [3:0] state;

   modport master (
      input  opcode, func3, func7, zero, sign,
      output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA, ALUSrcB,
             ResultSrc, ALUControl, ImmSrc, instr_done, state
   );

   modport slave (
      output opcode, func3, func7, zero, sign,
      input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA, ALUSrcB,
             ResultSrc, ALUControl, ImmSrc, instr_done, state
   );
endinterface

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle RV32I datapath (fetch/decode/execute/mem/wb).
// Define CTRL_ILLEGAL_TRAP_EN to halt on illegal instructions instead of treating them as NOPs.
module multicycle_controller (
   input  logic                    clk,
   input  logic                    rst,
   multicycle_controller_if.master bus
);
   typedef enum logic [3:0] {
      FETCH    = 4'h0, DECODE   = 4'h1, MEMADR = 4'h2, MEMREAD = 4'h3,
      MEMWB    = 4'h4, MEMWRITE = 4'h5, EXECR  = 4'h6, EXECI   = 4'h7,
      ALUWB    = 4'h8, BRANCH   = 4'h9, JAL    = 4'hA, JALR    = 4'hB,
      JALRLINK = 4'hC, LUI      = 4'hD, HALT   = 4'hF
   } state_t;

   localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LW = 7'b0000011,
                          OP_SW = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                          OP_JALR = 7'b1100111, OP_LUI = 7'b0110111;
   localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010,
                          ALU_OR = 3'b011, ALU_XOR = 3'b100, ALU_SLT = 3'b101;
   localparam logic [2:0] IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010,
                          IMM_J = 3'b011, IMM_U = 3'b100;

   state_t     state_q, state_d;
   logic [2:0] alu_op;
   logic       alu_ok, legal, br_taken;
   logic       pc_write, adr_src, mem_write, ir_write, reg_write, done;
   logic [1:0] src_a, src_b, result_src;
   logic [2:0] alu_ctrl, imm_src;

   // sign and most func7 bits are unused: SLT-based branches test zero instead.
   logic unused_bits;
   assign unused_bits = ^{bus.sign, bus.func7[6], bus.func7[4:0]};

   // NOTE: state is sequential, so it is assigned with <= only; = here races readers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= FETCH;
      else      state_q <= state_d;
   end

   always_comb begin
      alu_op = ALU_ADD;
      alu_ok = 1'b1;
      case (bus.func3)
         3'b000:  alu_op = (bus.opcode == OP_R && bus.func7[5]) ? ALU_SUB : ALU_ADD;
         3'b111:  alu_op = ALU_AND;
         3'b110:  alu_op = ALU_OR;
         3'b100:  alu_op = ALU_XOR;
         3'b010:  alu_op = ALU_SLT;
         default: alu_ok = 1'b0;
      endcase
   end

   always_comb begin
      case (bus.opcode)
         OP_R, OP_I:      legal = alu_ok;
         OP_LW, OP_SW:    legal = (bus.func3 == 3'b010);
         OP_BR:           legal = bus.func3 inside {3'b000, 3'b001, 3'b100, 3'b101};
         OP_JALR:         legal = (bus.func3 == 3'b000);
         OP_JAL, OP_LUI:  legal = 1'b1;
         default:         legal = 1'b0;
      endcase
   end

   // beq/bge are taken on a zero result, bne/blt on non-zero (SUB and SLT alike).
   always_comb begin
      case (bus.func3)
         3'b000, 3'b101: br_taken = bus.zero;
         3'b001, 3'b100: br_taken = !bus.zero;
         default:        br_taken = 1'b0;
      endcase
   end

   // NOTE: every output gets a default before the case so no path infers a latch.
   always_comb begin
      state_d    = state_q;
      pc_write   = 1'b0;
      adr_src    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      done       = 1'b0;
      src_a      = 2'b00;
      src_b      = 2'b00;
      result_src = 2'b00;
      alu_ctrl   = ALU_ADD;
      imm_src    = IMM_I;
      case (state_q)
         FETCH: begin
            ir_write = 1'b1; src_b = 2'b10; result_src = 2'b10; pc_write = 1'b1;
            state_d  = DECODE;
         end
         DECODE: begin
            src_a   = 2'b01; src_b = 2'b01;
            imm_src = (bus.opcode == OP_JAL) ? IMM_J : IMM_B;
            if (!legal) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
               state_d = HALT;
`else
               state_d = FETCH;
               done    = 1'b1;
`endif
            end else begin
               case (bus.opcode)
                  OP_LW, OP_SW: state_d = MEMADR;
                  OP_R:         state_d = EXECR;
                  OP_I:         state_d = EXECI;
                  OP_BR:        state_d = BRANCH;
                  OP_JAL:       state_d = JAL;
                  OP_JALR:      state_d = JALR;
                  OP_LUI:       state_d = LUI;
                  default:      state_d = FETCH;
               endcase
            end
         end
         MEMADR: begin
            src_a   = 2'b10; src_b = 2'b01;
            imm_src = (bus.opcode == OP_SW) ? IMM_S : IMM_I;
            state_d = (bus.opcode == OP_SW) ? MEMWRITE : MEMREAD;
         end
         MEMREAD:  begin adr_src = 1'b1; state_d = MEMWB; end
         MEMWB:    begin result_src = 2'b01; reg_write = 1'b1; done = 1'b1; state_d = FETCH; end
         MEMWRITE: begin adr_src = 1'b1; mem_write = 1'b1; done = 1'b1; state_d = FETCH; end
         EXECR:    begin src_a = 2'b10; alu_ctrl = alu_op; state_d = ALUWB; end
         EXECI: begin
            src_a = 2'b10; src_b = 2'b01; alu_ctrl = alu_op; state_d = ALUWB;
         end
         ALUWB:    begin reg_write = 1'b1; done = 1'b1; state_d = FETCH; end
         BRANCH: begin
            src_a    = 2'b10;
            alu_ctrl = bus.func3[2] ? ALU_SLT : ALU_SUB;
            pc_write = br_taken; done = 1'b1; state_d = FETCH;
         end
         JAL: begin
            src_a = 2'b01; src_b = 2'b10; pc_write = 1'b1; state_d = ALUWB;
         end
         JALR: begin
            src_a = 2'b10; src_b = 2'b01; result_src = 2'b10; pc_write = 1'b1;
            state_d = JALRLINK;
         end
         JALRLINK: begin
            src_a = 2'b01; src_b = 2'b10; result_src = 2'b10; reg_write = 1'b1;
            done  = 1'b1; state_d = FETCH;
         end
         LUI: begin
            imm_src = IMM_U; result_src = 2'b11; reg_write = 1'b1; done = 1'b1;
            state_d = FETCH;
         end
         HALT:    state_d = HALT;
         default: state_d = FETCH;
      endcase
   end

   // Reset gates outputs combinationally so an aborted instruction writes nothing.
   assign bus.PCWrite    = rst & pc_write;
   assign bus.AdrSrc     = rst & adr_src;
   assign bus.MemWrite   = rst & mem_write;
   assign bus.IRWrite    = rst & ir_write;
   assign bus.RegWrite   = rst & reg_write;
   assign bus.instr_done = rst & done;
   assign bus.ALUSrcA    = rst ? src_a      : 2'b00;
   assign bus.ALUSrcB    = rst ? src_b      : 2'b00;
   assign bus.ResultSrc  = rst ? result_src : 2'b00;
   assign bus.ALUControl = rst ? alu_ctrl   : 3'b000;
   assign bus.ImmSrc     = rst ? imm_src    : 3'b000;
   assign bus.state      = rst ? state_q    : 4'h0;
endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: drives a small behavioural RV32I datapath with the
// controller's outputs and scores architectural results and per-instruction timing.
module tb_multicycle_controller;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   multicycle_controller_if bus ();
   multicycle_controller dut (.clk(clk), .rst(rst), .bus(bus));

   // ---------------- behavioural datapath ----------------
   logic [31:0] mem [0:255];
   logic [31:0] rf  [0:31];
   logic [31:0] m_pc, m_oldpc, m_ir, m_a, m_b, m_aluout, m_data;
   logic [31:0] adr, rdata, imm_ext, src_a, src_b, alu_res, result;

   always_comb begin
      adr   = bus.AdrSrc ? m_aluout : m_pc;
      rdata = mem[adr[9:2]];
      case (bus.ImmSrc)
         3'b001:  imm_ext = {{20{m_ir[31]}}, m_ir[31:25], m_ir[11:7]};
         3'b010:  imm_ext = {{19{m_ir[31]}}, m_ir[31], m_ir[7], m_ir[30:25], m_ir[11:8], 1'b0};
         3'b011:  imm_ext = {{11{m_ir[31]}}, m_ir[31], m_ir[19:12], m_ir[20], m_ir[30:21], 1'b0};
         3'b100:  imm_ext = {m_ir[31:12], 12'b0};
         default: imm_ext = {{20{m_ir[31]}}, m_ir[31:20]};
      endcase
      case (bus.ALUSrcA)
         2'b01:   src_a = m_oldpc;
         2'b10:   src_a = m_a;
         default: src_a = m_pc;
      endcase
      case (bus.ALUSrcB)
         2'b01:   src_b = imm_ext;
         2'b10:   src_b = 32'd4;
         default: src_b = m_b;
      endcase
      case (bus.ALUControl)
         3'b001:  alu_res = src_a - src_b;
         3'b010:  alu_res = src_a & src_b;
         3'b011:  alu_res = src_a | src_b;
         3'b100:  alu_res = src_a ^ src_b;
         3'b101:  alu_res = {31'b0, $signed(src_a) < $signed(src_b)};
         default: alu_res = src_a + src_b;
      endcase
      case (bus.ResultSrc)
         2'b01:   result = m_data;
         2'b10:   result = alu_res;
         2'b11:   result = imm_ext;
         default: result = m_aluout;
      endcase
   end

   assign bus.opcode = m_ir[6:0];
   assign bus.func3  = m_ir[14:12];
   assign bus.func7  = m_ir[31:25];
   assign bus.zero   = (alu_res == 32'd0);
   assign bus.sign   = alu_res[31];

   always @(posedge clk) begin
      if (bus.IRWrite) begin
         m_ir    <= rdata;
         m_oldpc <= m_pc;
      end
      m_a      <= rf[m_ir[19:15]];
      m_b      <= rf[m_ir[24:20]];
      m_data   <= rdata;
      m_aluout <= alu_res;
      if (bus.PCWrite) m_pc <= result;
      if (bus.RegWrite && m_ir[11:7] != 5'd0) rf[m_ir[11:7]] <= result;
      if (bus.MemWrite) mem[adr[9:2]] <= m_b;
   end

   // ---------------- encoders ----------------
   function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1,
                                         input logic [2:0] f3, input int rd);
      return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
   endfunction
   function automatic logic [31:0] enc_i(input logic [11:0] imm, input int rs1, input logic [2:0] f3,
                                         input int rd, input logic [6:0] op);
      return {imm, 5'(rs1), f3, 5'(rd), op};
   endfunction
   function automatic logic [31:0] enc_s(input logic [11:0] imm, input int rs2, input int rs1);
      return {imm[11:5], 5'(rs2), 5'(rs1), 3'b010, imm[4:0], 7'b0100011};
   endfunction
   function automatic logic [31:0] enc_b(input logic [12:0] imm, input int rs2, input int rs1,
                                         input logic [2:0] f3);
      return {imm[12], imm[10:5], 5'(rs2), 5'(rs1), f3, imm[4:1], imm[11], 7'b1100011};
   endfunction
   function automatic logic [31:0] enc_j(input logic [20:0] imm, input int rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], 5'(rd), 7'b1101111};
   endfunction

   localparam logic [6:0] OPI = 7'b0010011;

   // ---------------- checking and scoreboard ----------------
   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   typedef enum int {K_PC, K_REG, K_MEM, K_LAT, K_RW, K_RWCYC, K_MW, K_MWADR} kind_t;
   typedef struct {
      string       tag;
      kind_t       kind;
      int          idx;
      logic [31:0] val;
   } exp_t;
   exp_t sb[$];

   int          o_lat, o_rw, o_rwcyc, o_mw;
   logic [31:0] o_mwadr;

   task automatic push_exp(input string tag, input kind_t k, input int idx, input logic [31:0] v);
      exp_t e;
      e.tag = tag; e.kind = k; e.idx = idx; e.val = v;
      sb.push_back(e);
   endtask

   function automatic logic [31:0] observe(input kind_t k, input int idx);
      case (k)
         K_PC:    return m_pc;
         K_REG:   return rf[idx];
         K_MEM:   return mem[idx];
         K_LAT:   return 32'(o_lat);
         K_RW:    return 32'(o_rw);
         K_RWCYC: return 32'(o_rwcyc);
         K_MW:    return 32'(o_mw);
         default: return o_mwadr;
      endcase
   endfunction

   function automatic logic [31:0] outs();
      return {14'b0, bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite,
              bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ALUControl, bus.ImmSrc, bus.instr_done};
   endfunction

   // Called while the controller sits in FETCH, between clock edges.
   task automatic exec(input logic [31:0] instr);
      bit got = 1'b0;
      int cyc = 0;
      exp_t e;
      mem[m_pc[9:2]] = instr;
      o_rw = 0; o_rwcyc = 0; o_mw = 0; o_mwadr = 32'd0;
      while (!got && cyc < 16) begin
         cyc++;
         if (bus.RegWrite) begin o_rw++; o_rwcyc = cyc; end
         if (bus.MemWrite) begin o_mw++; o_mwadr = adr; end
         if (bus.instr_done) got = 1'b1;
         @(negedge clk);
      end
      o_lat = got ? cyc : 0;
      check("done_seen", {31'b0, got}, 32'd1);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check(e.tag, observe(e.kind, e.idx), e.val);
      end
   endtask

   task automatic set_pc(input logic [31:0] v);
      m_pc = v;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'd0;
      for (int i = 0; i < 32; i++) rf[i] = 32'd0;
      m_pc = 0; m_oldpc = 0; m_ir = 0; m_a = 0; m_b = 0; m_aluout = 0; m_data = 0;
      rst = 1'b0;

      // Reset: FETCH encoding, every output held at zero.
      repeat (2) @(negedge clk);
      check("rst_state", {28'b0, bus.state}, 32'd0);
      check("rst_outs", outs(), 32'd0);
      @(negedge clk);
      check("rst_pc", m_pc, 32'd0);
      rst = 1'b1;
      #1;
      check("fetch_irwrite", {31'b0, bus.IRWrite}, 32'd1);

      // addi x1,x0,5
      push_exp("addi_lat", K_LAT, 0, 4);
      push_exp("addi_x1", K_REG, 1, 5);
      push_exp("addi_pc", K_PC, 0, 32'h4);
      push_exp("addi_rw", K_RW, 0, 1);
      push_exp("addi_rwcyc", K_RWCYC, 0, 4);
      push_exp("addi_mw", K_MW, 0, 0);
      exec(enc_i(12'd5, 0, 3'b000, 1, OPI));

      // sw x1,8(x0) then lw x2,8(x0); code kept away from data word 8
      set_pc(32'h100);
      push_exp("sw_lat", K_LAT, 0, 4);
      push_exp("sw_mem", K_MEM, 2, 5);
      push_exp("sw_mw", K_MW, 0, 1);
      push_exp("sw_mwadr", K_MWADR, 0, 32'h8);
      push_exp("sw_rw", K_RW, 0, 0);
      push_exp("sw_pc", K_PC, 0, 32'h104);
      exec(enc_s(12'd8, 1, 0));
      push_exp("lw_lat", K_LAT, 0, 5);
      push_exp("lw_x2", K_REG, 2, 5);
      push_exp("lw_rwcyc", K_RWCYC, 0, 5);
      push_exp("lw_pc", K_PC, 0, 32'h108);
      exec(enc_i(12'd8, 0, 3'b010, 2, 7'b0000011));

      // Reset in the middle of sw x1,12(x0): no store may land.
      mem[32'h108 >> 2] = enc_s(12'd12, 1, 0);
      repeat (2) @(negedge clk);
      check("abort_in_memadr", {28'b0, bus.state}, 32'h2);
      rst = 1'b0;
      #1;
      check("abort_state", {28'b0, bus.state}, 32'd0);
      repeat (2) begin
         @(negedge clk);
         check("abort_outs", outs(), 32'd0);
      end
      rst = 1'b1;
      #1;
      check("abort_mem", mem[3], 32'd0);

      // Branches at 0x10, offset +12
      rf[3] = 32'd7; rf[4] = 32'd7; rf[5] = 32'hFFFF_FFFF; rf[6] = 32'd1;
      set_pc(32'h10); push_exp("beq_eq_lat", K_LAT, 0, 3); push_exp("beq_eq_pc", K_PC, 0, 32'h1C);
      push_exp("beq_rw", K_RW, 0, 0);
      exec(enc_b(13'd12, 4, 3, 3'b000));
      set_pc(32'h10); push_exp("beq_ne_pc", K_PC, 0, 32'h14);
      exec(enc_b(13'd12, 5, 3, 3'b000));
      set_pc(32'h10); push_exp("bne_ne_pc", K_PC, 0, 32'h1C);
      exec(enc_b(13'd12, 5, 3, 3'b001));
      set_pc(32'h10); push_exp("bne_eq_pc", K_PC, 0, 32'h14);
      exec(enc_b(13'd12, 4, 3, 3'b001));
      set_pc(32'h10); push_exp("blt_pc", K_PC, 0, 32'h1C);
      exec(enc_b(13'd12, 6, 5, 3'b100));
      set_pc(32'h10); push_exp("bge_pc", K_PC, 0, 32'h14);
      exec(enc_b(13'd12, 6, 5, 3'b101));
      set_pc(32'h10); push_exp("bge_rev_pc", K_PC, 0, 32'h1C);
      exec(enc_b(13'd12, 5, 6, 3'b101));

      // R-type on x5=-1, x6=1
      set_pc(32'h200);
      push_exp("add_lat", K_LAT, 0, 4); push_exp("add_x7", K_REG, 7, 32'd0);
      exec(enc_r(7'h00, 6, 5, 3'b000, 7));
      push_exp("sub_x7", K_REG, 7, 32'hFFFF_FFFE); exec(enc_r(7'h20, 6, 5, 3'b000, 7));
      push_exp("and_x7", K_REG, 7, 32'd1);         exec(enc_r(7'h00, 6, 5, 3'b111, 7));
      push_exp("or_x7",  K_REG, 7, 32'hFFFF_FFFF); exec(enc_r(7'h00, 6, 5, 3'b110, 7));
      push_exp("xor_x7", K_REG, 7, 32'hFFFF_FFFE); exec(enc_r(7'h00, 6, 5, 3'b100, 7));
      push_exp("slt_x7", K_REG, 7, 32'd1);         exec(enc_r(7'h00, 6, 5, 3'b010, 7));
      push_exp("slt_rev_x7", K_REG, 7, 32'd0);     exec(enc_r(7'h00, 5, 6, 3'b010, 7));

      // I-ALU; imm 0x400 sets func7[5] but must still add
      push_exp("addi_neg", K_REG, 8, 32'hFFFF_FFFE); exec(enc_i(12'hFFD, 6, 3'b000, 8, OPI));
      push_exp("addi_b30", K_REG, 8, 32'h401);       exec(enc_i(12'h400, 6, 3'b000, 8, OPI));
      push_exp("andi_x8",  K_REG, 8, 32'hF0);        exec(enc_i(12'h0F0, 5, 3'b111, 8, OPI));
      push_exp("ori_x8",   K_REG, 8, 32'h101);       exec(enc_i(12'h100, 6, 3'b110, 8, OPI));
      push_exp("xori_x8",  K_REG, 8, 32'hFFFF_FF00); exec(enc_i(12'h0FF, 5, 3'b100, 8, OPI));
      push_exp("slti_x8",  K_REG, 8, 32'd1);         exec(enc_i(12'h000, 5, 3'b010, 8, OPI));

      // lui x9,0x12345
      push_exp("lui_lat", K_LAT, 0, 3); push_exp("lui_x9", K_REG, 9, 32'h1234_5000);
      exec({20'h12345, 5'd9, 7'b0110111});

      // jal x1,+0x20 at 0x40; jalr x0,0(x1); jalr x10,4(x1)
      set_pc(32'h40);
      push_exp("jal_lat", K_LAT, 0, 4); push_exp("jal_pc", K_PC, 0, 32'h60);
      push_exp("jal_x1", K_REG, 1, 32'h44);
      exec(enc_j(21'h20, 1));
      push_exp("jalr_lat", K_LAT, 0, 4); push_exp("jalr_pc", K_PC, 0, 32'h44);
      push_exp("jalr_rwcyc", K_RWCYC, 0, 4);
      exec(enc_i(12'd0, 1, 3'b000, 0, 7'b1100111));
      push_exp("jalr_link_pc", K_PC, 0, 32'h48); push_exp("jalr_link_x10", K_REG, 10, 32'h48);
      exec(enc_i(12'd4, 1, 3'b000, 10, 7'b1100111));

      // Illegal instruction handling
      set_pc(32'h300);
`ifdef CTRL_ILLEGAL_TRAP_EN
      mem[32'h300 >> 2] = 32'h0000_007F;
      for (int i = 0; i < 10 && bus.state != 4'hF; i++) @(negedge clk);
      check("halt_state", {28'b0, bus.state}, 32'hF);
      repeat (3) begin
         @(negedge clk);
         check("halt_outs", outs(), 32'd0);
      end
      check("halt_stuck", {28'b0, bus.state}, 32'hF);
      check("halt_pc", m_pc, 32'h304);
      rst = 1'b0;
      #1;
      check("halt_rst_state", {28'b0, bus.state}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      push_exp("recover_lat", K_LAT, 0, 4); push_exp("recover_x11", K_REG, 11, 32'd3);
      exec(enc_i(12'd3, 0, 3'b000, 11, OPI));
`else
      push_exp("ill_lat", K_LAT, 0, 2); push_exp("ill_pc", K_PC, 0, 32'h304);
      push_exp("ill_rw", K_RW, 0, 0); push_exp("ill_mw", K_MW, 0, 0);
      exec(32'h0000_007F);
      push_exp("ill_f3_lat", K_LAT, 0, 2); push_exp("ill_f3_pc", K_PC, 0, 32'h308);
      push_exp("ill_f3_x7", K_REG, 7, 32'd0);
      exec(enc_r(7'h00, 6, 5, 3'b001, 7));
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Moore-style control FSM that sequences the team's multicycle RV32I datapath: one instruction at a time through fetch, decode, execute, memory and writeback. Drives every datapath enable and mux select from `opcode`, `func3`, `func7`, `zero` and `sign`, and emits a one-cycle retire pulse per instruction. Sits beside the datapath at the CPU top level; no other block drives the datapath controls.

## Interface
- No parameters; all widths are fixed by the datapath.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `opcode` in 7, `func3` in 3, `func7` in 7: fields of the instruction register.
- `zero` in 1: ALU result is zero. `sign` in 1: ALU result bit 31.
- `PCWrite`, `AdrSrc`, `MemWrite`, `IRWrite`, `RegWrite` out 1: datapath enables and selects.
- `ALUSrcA` out 2: 00 PC, 01 OldPC, 10 A.
- `ALUSrcB` out 2: 00 B, 01 ImmExt, 10 constant 4.
- `ResultSrc` out 2: 00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt.
- `ALUControl` out 3: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT.
- `ImmSrc` out 3: 000 I, 001 S, 010 B, 011 J, 100 U.
- `instr_done` out 1: one-cycle pulse in the final state of each instruction.
- `state` out 4: current state encoding, for debug.

## Operation
- Supported opcodes:
  - R-type 0110011: add, sub, and, or, xor, slt.
  - I-ALU 0010011: addi, andi, ori, xori, slti.
  - lw 0000011, sw 0100011.
  - Branch 1100011: beq, bne, blt, bge.
  - jal 1101111, jalr 1100111, lui 0110111.
- Unlisted outputs are 0 in every state.
- States and required outputs:
  - FETCH: AdrSrc=0, IRWrite=1, A=00, B=10, ADD, ResultSrc=10, PCWrite=1. Next: DECODE.
  - DECODE: A=01, B=01, ADD. ImmSrc=J if jal, otherwise B, so ALUOut holds the branch or jal target.
  - DECODE next state: lw/sw → MEMADR; R → EXECR; I-ALU → EXECI; branch → BRANCH; jal → JAL; jalr → JALR; lui → LUI.
  - MEMADR: A=10, B=01, ADD, ImmSrc=I for lw or S for sw. Next: MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD: AdrSrc=1, ResultSrc=00. Next: MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1, done. Next: FETCH.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1, done. Next: FETCH.
  - EXECR: A=10, B=00, ALU per decode. EXECI: A=10, B=01, ImmSrc=I, ALU per decode. Both go to ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1, done. Next: FETCH.
  - BRANCH: A=10, B=00, SUB for beq/bne or SLT for blt/bge, ResultSrc=00, done. Next: FETCH.
  - BRANCH PCWrite: beq→zero, bne→!zero, blt→!zero, bge→zero. SLT yields 1 when taken, so the SLT cases test `zero`, not `sign`.
  - JAL: A=01, B=10, ADD (ALUOut becomes OldPC+4), ResultSrc=00, PCWrite=1. Next: ALUWB.
  - JALR: A=10, B=01, ImmSrc=I, ADD, ResultSrc=10, PCWrite=1. Next: JALRLINK.
  - JALRLINK: A=01, B=10, ADD, ResultSrc=10, RegWrite=1, done. Next: FETCH.
  - LUI: ImmSrc=U, ResultSrc=11, RegWrite=1, done. Next: FETCH.
- ALU decode:
  - R-type func3: 000 gives SUB if func7[5] else ADD; 111 AND; 110 OR; 100 XOR; 010 SLT.
  - I-ALU: same mapping, except func3 000 is always ADD.
- Illegal instruction: unlisted opcode, or unlisted func3 within a supported opcode. Handling is set by the macro below.

## Timing
- While `rst`=0:
  - State is FETCH.
  - PCWrite, MemWrite, IRWrite and RegWrite are forced 0 combinationally.
  - All selects are 0, `instr_done`=0, `state`=0.
- The first fetch commits on the first rising edge after `rst` rises.
- Reset mid-instruction aborts immediately, with no partial writes after assertion.
- Instruction latency in cycles: lw 5; sw, R, I, jal, jalr 4; branch and lui 3.
- `instr_done` is high exactly once per instruction, in its last cycle.
- Outputs are purely state-decoded plus combinational opcode/func3/zero/sign terms. There is no registered output delay.

## Configuration
- `CTRL_ILLEGAL_TRAP_EN` defined:
  - An illegal instruction in DECODE transitions to HALT.
  - HALT holds all enables at 0 and `instr_done` at 0 until reset.
  - `state` reads 4'hF in HALT.
- `CTRL_ILLEGAL_TRAP_EN` undefined:
  - An illegal instruction is a NOP: DECODE goes to FETCH with `instr_done`=1.
  - No register, memory or extra PC write occurs.

## Test plan
- Reset release, then `addi x1,x0,5`: 4 cycles, one `instr_done` pulse, RegWrite only in ALUWB; x1=5 and PC=4.
- `sw x1,8(x0)` then `lw x2,8(x0)`: MemWrite high exactly 1 cycle at address 8; x2=5 after 5 cycles.
- `beq` with equal operands and offset +12 from PC=0x10: PC becomes 0x1C. The same case with unequal operands gives PC=0x14.
- `blt` with -1 vs 1: taken. `bge` with -1 vs 1: not taken.
- `jal x1,+0x20` at PC=0x40: PC=0x60, x1=0x44. Then `jalr x0,0(x1)` returns PC to 0x44.
- Opcode 0x7F, checked once with the macro and once without:
  - Trap build: HALT, `state`=4'hF, no enables, recovers only on reset.
  - NOP build: `instr_done` after 2 cycles, PC advances by 4.
